// File: rtl/cic_dec_sched_if.sv
// Handshake bundle between the CIC decimator and its scheduler.
// master: sample/config source; slave: cic_dec_sched.
interface cic_dec_sched_if;
    logic       in_valid;
    logic       cfg_wr;
    logic [2:0] cfg_os_sel;
    logic [2:0] os_sel;
    logic       dec_stb;
    logic       out_valid;
    logic       cfg_ack;
    logic       cfg_err;
    logic       busy;

    modport master (
        output in_valid, cfg_wr, cfg_os_sel,
        input  os_sel, dec_stb, out_valid, cfg_ack, cfg_err, busy
    );

    modport slave (
        input  in_valid, cfg_wr, cfg_os_sel,
        output os_sel, dec_stb, out_valid, cfg_ack, cfg_err, busy
    );
endinterface

// File: rtl/cic_dec_sched.sv
// CIC decimation scheduler: counts samples, strobes the comb once per
// period, applies ratio changes on period boundaries and masks outputs
// while the filter history flushes.
// Ports: clk, reset (sync, active high), bus (cic_dec_sched_if.slave),
// drop_cnt (16b, only with CIC_SCHED_DROP_CNT_EN defined).
module cic_dec_sched #(
    parameter int NSTG = 3,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    cic_dec_sched_if.slave       bus
`ifdef CIC_SCHED_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int SW = (NSTG < 2) ? 1 : $clog2(NSTG + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SETTLE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] lim;
    logic [2:0]      os_sel_q, os_sel_d;
    logic [2:0]      pend_q, pend_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            stb_q, stb_d;
    logic            ok_q, ok_d;
    logic            ov_q, ov_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            acc;
    logic            rej;
    logic            term;
    logic [2:0]      eff_pend;

    assign acc  = bus.cfg_wr && (bus.cfg_os_sel != 3'd7);
    assign rej  = bus.cfg_wr && (bus.cfg_os_sel == 3'd7);
    assign term = (state_q != IDLE) && bus.in_valid && (cnt_q == lim);
    // A request landing on the boundary cycle is the latest one.
    assign eff_pend = acc ? bus.cfg_os_sel : pend_q;

    // Last count of a period, R-1 with R = 2^(code+2).
    always_comb begin
        lim = '0;
        unique case (os_sel_q)
            3'd1:    lim = CNTW'(7);
            3'd2:    lim = CNTW'(15);
            3'd3:    lim = CNTW'(31);
            3'd4:    lim = CNTW'(63);
            3'd5:    lim = CNTW'(127);
            3'd6:    lim = CNTW'(255);
            default: lim = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc && bus.cfg_os_sel != 3'd0) state_d = SETTLE;
            end
            RUN: begin
                if (acc) state_d = DRAIN;
            end
            DRAIN: begin
                if (term) state_d = (eff_pend != 3'd0) ? SETTLE : IDLE;
            end
            SETTLE: begin
                if (acc)
                    state_d = DRAIN;
                else if (term && settle_q == SW'(1))
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic.
    always_comb begin
        cnt_d    = cnt_q;
        os_sel_d = os_sel_q;
        pend_d   = pend_q;
        settle_d = settle_q;
        stb_d    = term;
        ok_d     = term && (state_q == RUN || state_q == DRAIN);
        ov_d     = stb_q && ok_q;
        ack_d    = acc;
        err_d    = rej;
        busy_d   = (state_d == DRAIN) || (state_d == SETTLE);

        if (state_q == IDLE)
            cnt_d = '0;
        else if (bus.in_valid)
            cnt_d = term ? '0 : cnt_q + 1'b1;

        if (state_q == IDLE && acc && bus.cfg_os_sel != 3'd0)
            os_sel_d = bus.cfg_os_sel;
        else if (state_q == DRAIN && term)
            os_sel_d = eff_pend;

        if (acc && state_q != IDLE)
            pend_d = bus.cfg_os_sel;

        if (state_d == SETTLE && state_q != SETTLE)
            settle_d = SW'(NSTG);
        else if (state_q == SETTLE && term)
            settle_d = settle_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            os_sel_q <= '0;
            pend_q   <= '0;
            settle_q <= '0;
            stb_q    <= 1'b0;
            ok_q     <= 1'b0;
            ov_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            os_sel_q <= os_sel_d;
            pend_q   <= pend_d;
            settle_q <= settle_d;
            stb_q    <= stb_d;
            ok_q     <= ok_d;
            ov_q     <= ov_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

`ifdef CIC_SCHED_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    // Masked strobes, saturating.
    always_comb begin
        drop_d = drop_q;
        if (term && state_q == SETTLE && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`endif

    assign bus.os_sel    = os_sel_q;
    assign bus.dec_stb   = stb_q;
    assign bus.out_valid = ov_q;
    assign bus.cfg_ack   = ack_q;
    assign bus.cfg_err   = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cic_dec_sched.sv
// Scoreboard bench for cic_dec_sched: behavioural model predicts
// strobes, config responses and per-cycle outputs; a monitor compares.
module tb_cic_dec_sched;

    localparam int NSTG = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cic_dec_sched_if bus ();

`ifdef CIC_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    cic_dec_sched #(.NSTG(NSTG), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CIC_SCHED_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct {
        bit       rst;
        bit [2:0] os;
        bit       busy;
        int       drops;
    } cyc_t;

    cyc_t cyc_q[$];
    bit   stb_q[$];     // out_valid expected after each strobe
    int   cfg_q[$];     // 1 = ack, 2 = err

    int errors = 0;
    int checks = 0;

    // Model state: applied code, samples in current period, draining
    // toward a pending code, strobes still to mask.
    int  m_os, m_cnt, m_pend, m_mask, m_drops;
    bit  m_drain;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_running();
        return m_os != 0 && !m_drain && m_mask == 0;
    endfunction

    task automatic step(input bit r, input bit iv, input bit wr,
                        input bit [2:0] c);
        bit   stb, ov, acc;
        int   np;
        cyc_t e;
        reset          = r;
        bus.in_valid   = iv;
        bus.cfg_wr     = wr;
        bus.cfg_os_sel = c;
        @(posedge clk);
        stb = 0;
        ov  = 0;
        if (r) begin
            m_os = 0; m_cnt = 0; m_pend = 0; m_mask = 0;
            m_drain = 0; m_drops = 0;
        end else begin
            acc = wr && c != 3'd7;
            if (m_os != 0 && iv) begin
                if (m_cnt == (1 << (m_os + 2)) - 1) begin
                    stb = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (stb) begin
                ov = m_drain || m_mask == 0;
                if (!m_drain && m_mask > 0) begin
                    m_mask--;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (m_drain && stb) begin
                np = acc ? int'(c) : m_pend;
                m_os = np;
                m_drain = 0;
                m_mask = (np != 0) ? NSTG : 0;
                m_cnt = 0;
            end else if (acc) begin
                if (m_os == 0) begin
                    if (c != 3'd0) begin
                        m_os = c;
                        m_mask = NSTG;
                        m_cnt = 0;
                    end
                end else begin
                    m_drain = 1;
                    m_pend = c;
                end
            end
            if (stb) stb_q.push_back(ov);
            if (wr) cfg_q.push_back(acc ? 1 : 2);
        end
        e.rst   = r;
        e.os    = 3'(m_os);
        e.busy  = m_os != 0 && (m_drain || m_mask > 0);
        e.drops = m_drops;
        cyc_q.push_back(e);
        #1;
    endtask

    task automatic idle_n(input int n, input bit iv);
        for (int i = 0; i < n; i++) step(0, iv, 0, 0);
    endtask

    task automatic wait_run(input string name);
        int k;
        k = 0;
        while (!m_running() && k < 5000) begin
            step(0, 1, 0, 0);
            k++;
        end
        chk({name, "_run_timeout"}, int'(m_running()), 1);
    endtask

    // Monitor.
    bit pend_ov = 0;
    always @(negedge clk) begin : mon
        cyc_t e;
        bit   s;
        int   k;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("os_sel", int'(bus.os_sel), int'(e.os));
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("out_valid", int'(bus.out_valid), int'(pend_ov && !e.rst));
`ifdef CIC_SCHED_DROP_CNT_EN
            chk("drop_cnt", int'(drop_cnt), e.drops);
`endif
            chk("dec_stb", int'(bus.dec_stb), int'(stb_q.size() > 0));
            pend_ov = 0;
            if (stb_q.size() > 0) begin
                s = stb_q.pop_front();
                pend_ov = s;
            end
            k = (cfg_q.size() > 0) ? cfg_q.pop_front() : 0;
            chk("cfg_ack", int'(bus.cfg_ack), int'(k == 1));
            chk("cfg_err", int'(bus.cfg_err), int'(k == 2));
        end
    end

    initial begin
        int k;
        m_os = 0; m_cnt = 0; m_pend = 0; m_mask = 0; m_drain = 0; m_drops = 0;

        step(1, 0, 0, 0);
        step(1, 1, 1, 3'd4);
        idle_n(5, 1);

        // Code 1 from idle, continuous samples.
        step(0, 1, 1, 3'd1);
        idle_n(8 * 6, 1);

        // Move to code 3, then request code 5 at cnt 10.
        step(0, 1, 1, 3'd3);
        wait_run("c3");
        k = 0;
        while (m_cnt != 10 && k < 100) begin
            step(0, 1, 0, 0);
            k++;
        end
        chk("cnt10_timeout", m_cnt, 10);
        step(0, 1, 1, 3'd5);
        idle_n(32 + 128 * 5, 1);

        // Rejected code in RUN.
        step(0, 1, 1, 3'd7);
        idle_n(20, 1);

        // Drain to code 2 then overwritten by 0 -> idle.
        step(0, 1, 1, 3'd2);
        idle_n(3, 1);
        step(0, 1, 1, 3'd0);
        idle_n(300, 1);
        chk("idle_after_zero", m_os, 0);

        // Reset mid-settle with toggling samples.
        step(0, 1, 1, 3'd1);
        idle_n(12, 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(0, i[0], 0, 0);

        // Code 0 in idle is acked only.
        step(0, 1, 1, 3'd0);
        idle_n(10, 1);

        // Randomized traffic.
        for (int i = 0; i < 15000; i++) begin
            step($urandom_range(3999) == 0,
                 $urandom_range(9) != 0,
                 $urandom_range(199) == 0,
                 3'($urandom_range(7)));
        end
        idle_n(4, 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cic_dec_sched.md
# cic_dec_sched

Decimation scheduler for the CIC decimator comb stage. It runs on the fast modulator clock and counts valid input samples. It emits one comb-update strobe per decimation period and owns the `os_sel` value that the comb and integrator sections consume. Ratio changes are applied only on period boundaries, and the outputs that follow each change are masked until the filter history has flushed.

## Interface
Parameters:
- `NSTG`, 3: number of decimated outputs discarded after any ratio change (filter order).
- `CNTW`, 8: width of the in-period sample counter; must be ≥ 8 (largest ratio is 256).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: one modulator sample is present this cycle.
- `cfg_wr`, in, 1: single-cycle request to change the ratio.
- `cfg_os_sel`, in, 3: requested ratio code, sampled when `cfg_wr` is high.
- `os_sel`, out, 3: applied ratio code driven to the filter; 0 means filter disabled/cleared.
- `dec_stb`, out, 1: comb update strobe, one cycle wide, once per period.
- `out_valid`, out, 1: the comb output produced by the preceding `dec_stb` is usable.
- `cfg_ack`, out, 1: one-cycle pulse when a request is accepted.
- `cfg_err`, out, 1: one-cycle pulse when a request is rejected (code 7).
- `busy`, out, 1: high in DRAIN or SETTLE.

## Operation
- Ratio: R = 2^(os_sel+2), giving 8, 16, 32, 64, 128 and 256 for codes 1–6. Codes 0 and 7 define no ratio.
- Counter `cnt`:
  - Increments on `in_valid`.
  - When `in_valid` arrives with `cnt == R-1`: `cnt` wraps to 0 and `dec_stb` is asserted.
  - Held at 0 in IDLE.
- States:
  - IDLE:
    - `os_sel` = 0; no strobes.
    - On an accepted `cfg_wr` with a nonzero code: `os_sel` takes the new code, `cnt` = 0, go to SETTLE.
    - Code 0 in IDLE is acked and has no effect.
  - RUN:
    - Every `dec_stb` is followed by `out_valid`.
    - On an accepted `cfg_wr`: latch the code into `pend`, go to DRAIN.
  - DRAIN:
    - Counting and strobes continue; `out_valid` stays asserted for these strobes.
    - On the cycle `dec_stb` fires: `os_sel` ← `pend`, `cnt` = 0.
    - Next state is SETTLE if `pend` ≠ 0, otherwise IDLE.
    - A further `cfg_wr` overwrites `pend` (latest wins).
  - SETTLE:
    - `out_valid` is suppressed for the first NSTG strobes; `settle_cnt` counts them down.
    - On the NSTG-th strobe, go to RUN. The strobe after that is the first one with `out_valid`.
    - On an accepted `cfg_wr`: behave as in RUN (go to DRAIN).
- Request rules:
  - `cfg_wr` with code 7 raises `cfg_err` and has no other effect.
  - Every other `cfg_wr` raises `cfg_ack`.
- `in_valid` together with `cfg_wr` in the same cycle: the sample is counted under the old ratio.
- Reset at any point:
  - Forces IDLE; `cnt`, `pend` and `settle_cnt` return to 0.
  - Any pending request is lost.

## Timing
- All outputs are registered.
- Reset values: `os_sel` = 0, `dec_stb` = 0, `out_valid` = 0, `cfg_ack` = 0, `cfg_err` = 0, `busy` = 0.
- `dec_stb` is high in cycle t+1 when the terminal `in_valid` is sampled at edge t.
- `out_valid` is high exactly one cycle after the `dec_stb` it qualifies, i.e. cycle t+2.
- `cfg_ack` / `cfg_err` are high in the cycle after `cfg_wr`.
- `os_sel` changes in the same cycle as the boundary `dec_stb`. That strobe is computed with the old ratio; the new ratio counts from the next `in_valid`.
- Throughput: `in_valid` may be high every cycle. Minimum `dec_stb` spacing is 8 cycles.
- `busy` changes in the same cycle as the state register.

## Configuration
- Macro `CIC_SCHED_DROP_CNT_EN`.
- Defined:
  - Adds output port `drop_cnt` (out, 16 bits).
  - `drop_cnt` counts strobes masked in SETTLE; it saturates at 0xFFFF and is cleared only by `reset`.
- Undefined:
  - The port is absent and no counter logic is generated.
  - All other behaviour is identical.

## Test plan
- Reset, then `cfg_wr` with code 1 and continuous `in_valid`:
  - `cfg_ack` in the next cycle; `os_sel` = 1.
  - `dec_stb` every 8 cycles.
  - First 3 strobes have no `out_valid`; the 4th strobe gives `out_valid` one cycle later.
- Code 3 in RUN, `cfg_wr` with code 5 at `cnt` = 10:
  - `os_sel` stays 3 and `busy` = 1 until the period ends at the 32nd sample.
  - Then `os_sel` = 5 and strobes come every 128 samples.
  - 3 masked strobes, then `out_valid` resumes.
- `cfg_wr` with code 7 in RUN: `cfg_err` pulse, no `cfg_ack`, state and `os_sel` unchanged.
- DRAIN with `cfg_wr` code 2 followed by `cfg_wr` code 0 before the boundary:
  - At the boundary `os_sel` = 0 and the state is IDLE.
  - No further `dec_stb`; `busy` = 0.
- `reset` asserted mid-SETTLE with `in_valid` still toggling:
  - Next cycle all outputs are at their reset values and `os_sel` = 0.
  - No strobes until a new request.
- With `CIC_SCHED_DROP_CNT_EN` defined: two ratio changes → `drop_cnt` = 6; holds after further RUN strobes.
